// File: rtl/coloring_checker_n_if.sv
// rtl/coloring_checker_n_if.sv - sample/result bundle for coloring_checker_n
// Purpose: groups the colour-sample stream inputs and the checker result outputs.
// Signals:
//   in_valid     sample qualifier
//   color        colour sample, COLOR_W bits
//   adj_mask     forbidden-pair table, bit prev*N+cur set = prev->cur illegal
//   clear_sticky clears err_sticky / err_count
//   check        violation flag of the last accepted sample
//   run_len      current run length, saturating at RUN_MAX
//   err_sticky   sticky violation flag
//   err_count    saturating count of violating samples
interface coloring_checker_n_if #(
  parameter int COLOR_W = 2,
  parameter int RUN_MAX = 3,
  parameter int CNT_W   = 8
) ();
  localparam int N    = 1 << COLOR_W;
  localparam int RL_W = $clog2(RUN_MAX + 1);

  logic               in_valid;
  logic [COLOR_W-1:0] color;
  logic [N*N-1:0]     adj_mask;
  logic               clear_sticky;
  logic               check;
  logic [RL_W-1:0]    run_len;
  logic               err_sticky;
  logic [CNT_W-1:0]   err_count;

  modport master (
    output in_valid, color, adj_mask, clear_sticky,
    input  check, run_len, err_sticky, err_count
  );

  modport slave (
    input  in_valid, color, adj_mask, clear_sticky,
    output check, run_len, err_sticky, err_count
  );
endinterface

// File: rtl/coloring_checker_n.sv
// rtl/coloring_checker_n.sv - streaming colour-sequence rule checker
// Purpose: flags run-length and forbidden-adjacency violations on a colour stream,
//          one cycle after each accepted sample, with sticky flag and saturating counter.
// Ports:
//   clk    clock, all state updates on rising edge
//   reset  synchronous active-high reset
//   bus    coloring_checker_n_if.slave (sample inputs, registered result outputs)
module coloring_checker_n #(
  parameter int COLOR_W  = 2,
  parameter int RUN_MAX  = 3,
  parameter int CNT_W    = 8,
  parameter int BREAK_EN = 1
) (
  input  logic                clk,
  input  logic                reset,
  coloring_checker_n_if.slave bus
);
  localparam int N    = 1 << COLOR_W;
  localparam int RL_W = $clog2(RUN_MAX + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t             r_state;
  logic [COLOR_W-1:0] r_prev;
  logic [RL_W-1:0]    r_run_len;
  logic               r_check;
  logic               r_err_sticky;
  logic [CNT_W-1:0]   r_err_count;

  logic               w_is_break;
  logic               w_same;
  logic [RL_W-1:0]    w_run_next;
  logic               w_adj_viol;
  logic               w_run_viol;
  logic               w_viol;

  // Top code acts as a break token only when enabled.
  assign w_is_break = (BREAK_EN != 0) && (bus.color == COLOR_W'(N - 1));
  assign w_same     = (r_state == TRACK) && (bus.color == r_prev);

  always_comb begin
    w_run_next = RL_W'(1);
    if (w_same) begin
      w_run_next = (r_run_len == RL_W'(RUN_MAX)) ? RL_W'(RUN_MAX) : r_run_len + RL_W'(1);
    end
  end

  // {prev, cur} is exactly prev*N+cur because N is a power of two.
  assign w_adj_viol = (r_state == TRACK) && !w_same && bus.adj_mask[{r_prev, bus.color}];
  // Saturated run keeps violating on every further same-colour sample.
  assign w_run_viol = (r_state == TRACK) && (w_run_next == RL_W'(RUN_MAX));
  assign w_viol     = !w_is_break && (w_adj_viol || w_run_viol);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_prev       <= '0;
      r_run_len    <= '0;
      r_check      <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_count  <= '0;
    end else begin
      if (bus.in_valid) begin
        if (w_is_break) begin
          r_state   <= IDLE;
          r_run_len <= '0;
          r_check   <= 1'b0;
        end else begin
          r_state   <= TRACK;
          r_prev    <= bus.color;
          r_run_len <= w_run_next;
          r_check   <= w_viol;
        end
      end

      // A violation in the same cycle as a clear wins: the count restarts at one.
      if (bus.in_valid && w_viol) begin
        r_err_sticky <= 1'b1;
        if (bus.clear_sticky) begin
          r_err_count <= CNT_W'(1);
        end else if (r_err_count != '1) begin
          r_err_count <= r_err_count + CNT_W'(1);
        end
      end else if (bus.clear_sticky) begin
        r_err_sticky <= 1'b0;
        r_err_count  <= '0;
      end
    end
  end

  assign bus.check      = r_check;
  assign bus.run_len    = r_run_len;
  assign bus.err_sticky = r_err_sticky;
  assign bus.err_count  = r_err_count;
endmodule

// File: tb/tb_coloring_checker_n.sv
// tb/tb_coloring_checker_n.sv - self-checking bench for coloring_checker_n
module tb_coloring_checker_n;
  localparam int RUN_MAX = 3;

  logic        clk;
  logic        reset;
  logic        t_valid;
  logic [1:0]  t_color;
  logic [15:0] t_mask;
  logic        t_clear;

  int n_checks;
  int n_errors;

  // Three configurations: 0 defaults, 1 BREAK_EN=0, 2 CNT_W=2.
  coloring_checker_n_if #(.COLOR_W(2), .RUN_MAX(RUN_MAX), .CNT_W(8)) if0 ();
  coloring_checker_n_if #(.COLOR_W(2), .RUN_MAX(RUN_MAX), .CNT_W(8)) if1 ();
  coloring_checker_n_if #(.COLOR_W(2), .RUN_MAX(RUN_MAX), .CNT_W(2)) if2 ();

  coloring_checker_n #(.COLOR_W(2), .RUN_MAX(RUN_MAX), .CNT_W(8), .BREAK_EN(1))
    u0 (.clk(clk), .reset(reset), .bus(if0));
  coloring_checker_n #(.COLOR_W(2), .RUN_MAX(RUN_MAX), .CNT_W(8), .BREAK_EN(0))
    u1 (.clk(clk), .reset(reset), .bus(if1));
  coloring_checker_n #(.COLOR_W(2), .RUN_MAX(RUN_MAX), .CNT_W(2), .BREAK_EN(1))
    u2 (.clk(clk), .reset(reset), .bus(if2));

  assign if0.in_valid = t_valid;  assign if1.in_valid = t_valid;  assign if2.in_valid = t_valid;
  assign if0.color    = t_color;  assign if1.color    = t_color;  assign if2.color    = t_color;
  assign if0.adj_mask = t_mask;   assign if1.adj_mask = t_mask;   assign if2.adj_mask = t_mask;
  assign if0.clear_sticky = t_clear;
  assign if1.clear_sticky = t_clear;
  assign if2.clear_sticky = t_clear;

  logic       d_check  [3];
  logic [1:0] d_run    [3];
  logic       d_sticky [3];
  logic [7:0] d_count  [3];

  assign d_check[0] = if0.check;  assign d_run[0] = if0.run_len;
  assign d_check[1] = if1.check;  assign d_run[1] = if1.run_len;
  assign d_check[2] = if2.check;  assign d_run[2] = if2.run_len;
  assign d_sticky[0] = if0.err_sticky;  assign d_count[0] = if0.err_count;
  assign d_sticky[1] = if1.err_sticky;  assign d_count[1] = if1.err_count;
  assign d_sticky[2] = if2.err_sticky;  assign d_count[2] = {6'b0, if2.err_count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: history of colours since last reset/break, rules evaluated on it.
  int m_hist   [3][$];
  int m_check  [3];
  int m_run    [3];
  int m_sticky [3];
  int m_count  [3];
  int cfg_break[3] = '{1, 0, 1};
  int cfg_cmax [3] = '{255, 255, 3};

  task automatic model_update(input bit v, input int c, input bit clr, input bit rst);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_hist[k].delete();
        m_check[k] = 0; m_run[k] = 0; m_sticky[k] = 0; m_count[k] = 0;
      end else if (v) begin
        int chk;
        int run;
        chk = 0;
        run = 0;
        if (cfg_break[k] != 0 && c == 3) begin
          m_hist[k].delete();
        end else begin
          if (m_hist[k].size() > 0) begin
            int last;
            last = m_hist[k][m_hist[k].size()-1];
            if (last != c && t_mask[last*4 + c]) chk = 1;
          end
          m_hist[k].push_back(c);
          if (m_hist[k].size() > 8) void'(m_hist[k].pop_front());
          for (int i = m_hist[k].size() - 1; i >= 0 && run < RUN_MAX; i--) begin
            if (m_hist[k][i] != c) break;
            run++;
          end
          if (run == RUN_MAX) chk = 1;
        end
        m_check[k] = chk;
        m_run[k]   = run;
        if (chk != 0) begin
          m_sticky[k] = 1;
          m_count[k]  = clr ? 1 : ((m_count[k] + 1 > cfg_cmax[k]) ? cfg_cmax[k] : m_count[k] + 1);
        end else if (clr) begin
          m_sticky[k] = 0; m_count[k] = 0;
        end
      end else if (clr) begin
        m_sticky[k] = 0; m_count[k] = 0;
      end
    end
  endtask

  // Drive one cycle, then sample outputs 1 time unit after the edge.
  task automatic step(input bit v, input int c, input bit clr, input bit rst);
    t_valid = v;
    t_color = 2'(c);
    t_clear = clr;
    reset   = rst;
    model_update(v, c, clr, rst);
    @(posedge clk);
    #1;
    t_valid = 1'b0;
    t_clear = 1'b0;
    reset   = 1'b0;
  endtask

  task automatic test_reset;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (d_check[k] !== 1'b0 || d_run[k] !== 2'd0 || d_sticky[k] !== 1'b0 || d_count[k] !== 8'd0) begin
        n_errors++;
        $display("FAIL reset cfg%0d: got chk=%b run=%0d sticky=%b cnt=%0d, want all 0",
                 k, d_check[k], d_run[k], d_sticky[k], d_count[k]);
      end
    end
  endtask

  task automatic test_run_limit;
    int exp_chk[4] = '{0, 0, 1, 1};
    int exp_run[4] = '{1, 2, 3, 3};
    t_mask = 16'h0012;
    step(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 2, 0, 0);
      n_checks++;
      if (d_check[0] !== 1'(exp_chk[i]) || d_run[0] !== 2'(exp_run[i])) begin
        n_errors++;
        $display("FAIL run_limit[%0d]: got chk=%b run=%0d, want chk=%0d run=%0d",
                 i, d_check[0], d_run[0], exp_chk[i], exp_run[i]);
      end
    end
    n_checks++;
    if (d_count[0] !== 8'd2 || d_sticky[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL run_limit_err: got cnt=%0d sticky=%b, want cnt=2 sticky=1", d_count[0], d_sticky[0]);
    end
  endtask

  task automatic test_adjacency;
    int seq_a[2] = '{1, 0};
    int exp_a[2] = '{0, 1};
    int seq_b[3] = '{0, 2, 0};
    t_mask = 16'h0012;
    step(0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      step(1, seq_a[i], 0, 0);
      n_checks++;
      if (d_check[0] !== 1'(exp_a[i])) begin
        n_errors++;
        $display("FAIL adj_10[%0d]: got %b, want %0d", i, d_check[0], exp_a[i]);
      end
    end
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, seq_b[i], 0, 0);
      n_checks++;
      if (d_check[0] !== 1'b0) begin
        n_errors++;
        $display("FAIL adj_020[%0d]: got %b, want 0", i, d_check[0]);
      end
    end
    step(0, 0, 0, 1);
    t_mask = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      step(1, seq_a[i], 0, 0);
      n_checks++;
      if (d_check[0] !== 1'b0) begin
        n_errors++;
        $display("FAIL adj_nomask[%0d]: got %b, want 0", i, d_check[0]);
      end
    end
    t_mask = 16'h0012;
  endtask

  task automatic test_break;
    int seq[5] = '{1, 1, 3, 1, 1};
    int exp_run[5] = '{1, 2, 0, 1, 2};
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, seq[i], 0, 0);
      n_checks++;
      if (d_check[0] !== 1'b0 || d_run[0] !== 2'(exp_run[i])) begin
        n_errors++;
        $display("FAIL break[%0d]: got chk=%b run=%0d, want chk=0 run=%0d", i, d_check[0], d_run[0], exp_run[i]);
      end
    end
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 3, 0, 0);
      n_checks++;
      if (d_check[1] !== (i == 2)) begin
        n_errors++;
        $display("FAIL nobreak[%0d]: got %b, want %0d", i, d_check[1], (i == 2));
      end
    end
  endtask

  task automatic test_gaps;
    bit v_seq[6]   = '{1, 0, 0, 1, 0, 1};
    int exp_run[6] = '{1, 1, 1, 2, 2, 3};
    int exp_chk[6] = '{0, 0, 0, 0, 0, 1};
    step(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      step(v_seq[i], v_seq[i] ? 2 : 1, 0, 0);
      n_checks++;
      if (d_check[0] !== 1'(exp_chk[i]) || d_run[0] !== 2'(exp_run[i])) begin
        n_errors++;
        $display("FAIL gaps[%0d]: got chk=%b run=%0d, want chk=%0d run=%0d",
                 i, d_check[0], d_run[0], exp_chk[i], exp_run[i]);
      end
    end
  endtask

  task automatic test_clear_sat;
    int exp_cnt[7] = '{0, 0, 1, 2, 3, 3, 3};
    step(0, 0, 0, 1);
    for (int i = 0; i < 7; i++) begin
      step(1, 0, 0, 0);
      n_checks++;
      if (d_count[2] !== 8'(exp_cnt[i])) begin
        n_errors++;
        $display("FAIL sat[%0d]: got cnt=%0d, want %0d", i, d_count[2], exp_cnt[i]);
      end
    end
    step(1, 0, 1, 0);
    n_checks++;
    if (d_sticky[2] !== 1'b1 || d_count[2] !== 8'd1) begin
      n_errors++;
      $display("FAIL clear_set_wins: got sticky=%b cnt=%0d, want sticky=1 cnt=1", d_sticky[2], d_count[2]);
    end
    step(0, 0, 1, 0);
    n_checks++;
    if (d_sticky[2] !== 1'b0 || d_count[2] !== 8'd0) begin
      n_errors++;
      $display("FAIL clear_idle: got sticky=%b cnt=%0d, want 0 0", d_sticky[2], d_count[2]);
    end
  endtask

  task automatic test_reset_mid;
    t_mask = 16'h0012;
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 2, 0, 0);
    step(1, 2, 0, 1);
    n_checks++;
    if (d_check[0] !== 1'b0 || d_run[0] !== 2'd0 || d_sticky[0] !== 1'b0 || d_count[0] !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_mid: got chk=%b run=%0d sticky=%b cnt=%0d, want all 0",
               d_check[0], d_run[0], d_sticky[0], d_count[0]);
    end
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    n_checks++;
    if (d_check[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid_hist: got %b, want 1", d_check[0]);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) t_mask = 16'($urandom);
      step($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 19) == 0,
           $urandom_range(0, 99) == 0);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (d_check[k] !== 1'(m_check[k]) || d_run[k] !== 2'(m_run[k]) ||
            d_sticky[k] !== 1'(m_sticky[k]) || d_count[k] !== 8'(m_count[k])) begin
          n_errors++;
          $display("FAIL random[%0d] cfg%0d: got chk=%b run=%0d sticky=%b cnt=%0d, want chk=%0d run=%0d sticky=%0d cnt=%0d",
                   n, k, d_check[k], d_run[k], d_sticky[k], d_count[k],
                   m_check[k], m_run[k], m_sticky[k], m_count[k]);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    t_valid  = 1'b0;
    t_color  = 2'd0;
    t_mask   = 16'h0012;
    t_clear  = 1'b0;
    #1;
    test_reset;
    test_run_limit;
    test_adjacency;
    test_break;
    test_gaps;
    test_clear_sat;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/coloring_checker_n.md
# coloring_checker_n

Parametrised, streaming colour-sequence rule checker. It generalises the fixed 2-bit, run-of-three colouring checker to any colour width, any run limit and a programmable forbidden-adjacency table. It adds input qualification, a break token, a sticky error flag and a saturating violation counter. It sits on a colour-sample stream and flags rule violations one cycle after each accepted sample.

## Interface
- COLOR_W, 2: colour code width; N = 2**COLOR_W codes.
- RUN_MAX, 3: run length of one colour that counts as a violation; legal range ≥ 2.
- CNT_W, 8: violation counter width.
- BREAK_EN, 1: when 1, code N-1 is a break token rather than a colour.
- RL_W, derived = $clog2(RUN_MAX+1): run_len width.

- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  sample qualifier; when 0, all state holds.
- color  in  COLOR_W  colour sample.
- adj_mask  in  N*N  forbidden-pair table. Bit prev*N+cur = 1 means the direct transition prev→cur is illegal. Sampled only with the accepted sample; may change between samples.
- clear_sticky  in  1  clears err_sticky and err_count.
- check  out  1  violation flag for the most recently accepted sample.
- run_len  out  RL_W  current run length, saturating at RUN_MAX.
- err_sticky  out  1  set by any violation; held until cleared.
- err_count  out  CNT_W  saturating count of violating samples.

## Operation
- Two-state FSM:
  - IDLE: no history.
  - TRACK: prev_color is valid.
- Reset: FSM=IDLE, prev_color=0, run_len=0, check=0, err_sticky=0, err_count=0.
- Accepted sample (in_valid=1), break token (BREAK_EN=1 and color=N-1):
  - Next state IDLE; run_len←0, check←0.
  - Sticky flag and counter are untouched.
- Accepted sample, ordinary colour c, from IDLE:
  - Next state TRACK; run_len←1, prev←c.
  - check←(RUN_MAX≤1 never; legal range excludes it) 0.
- Accepted sample, ordinary colour c, from TRACK:
  - same = (c==prev).
  - run_len←same ? min(run_len+1, RUN_MAX) : 1.
  - adj_viol = !same && adj_mask[prev*N+c].
  - run_viol = (new run_len == RUN_MAX).
  - check←adj_viol | run_viol; prev←c.
  - A run stays violating on every further same-colour sample, because run_len saturates.
- Violation bookkeeping, evaluated on each accepted sample whose new check=1:
  - err_sticky←1.
  - err_count←err_count+1, saturating at 2**CNT_W-1; no wrap.
- clear_sticky:
  - err_sticky←0 and err_count←0.
  - If a violating sample is accepted in the same cycle, set wins: err_sticky=1, err_count=1.
- in_valid=0: FSM, prev, run_len, check, err_sticky and err_count all hold. clear_sticky is still honoured.
- With BREAK_EN=0, code N-1 is an ordinary colour.

## Timing
- All outputs are registered.
- Latency: check, run_len, err_sticky and err_count reflect sample k in the cycle after its acceptance edge. They hold until the next accepted sample.
- One sample per cycle, back-to-back; no backpressure.
- reset dominates every other input in the same cycle, including mid-run and mid-violation.
- clear_sticky takes effect at the same edge it is sampled; outputs change one cycle later.

## Test plan
Defaults unless stated; adj_mask=16'h0012 (0→1 and 1→0 forbidden).

- Run limit: colours 2,2,2,2 back-to-back.
  - check=0,0,1,1.
  - run_len=1,2,3,3.
  - err_count=2, err_sticky=1.
- Adjacency:
  - Colours 1,0 → check=0,1.
  - Colours 0,2,0 → check=0,0,0.
  - Reload adj_mask=0, then 1,0 → check=0.
- Break token: colours 1,1,3,1,1.
  - check stays 0.
  - run_len=1,2,0,1,2.
  - With BREAK_EN=0, colours 3,3,3 → check on the third sample.
- Gaps: sample 2, 2-cycle in_valid=0, sample 2, idle, sample 2.
  - check rises only after the third accepted sample.
  - Outputs hold through the idle cycles.
- Clear/saturation:
  - CNT_W=2, seven consecutive 0s → err_count=1,2,3,3,3.
  - clear_sticky coincident with an accepted violating 0 → err_sticky=1, err_count=1.
  - clear_sticky with in_valid=0 → both clear to 0.
- Reset mid-operation: assert reset in the cycle after a violation.
  - Next cycle: check=0, run_len=0, err_sticky=0, err_count=0.
  - A following 1,0 → check=0,1 (no stale history).
